// File: rtl/hbus_arbiter_pkg.sv
// Shared types and constants for the high-memory/IO bus arbiter.
package hbus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hbus_state_e;

  localparam logic [7:0]  HBUS_ERR_DATA = 8'hff;
  localparam logic [15:0] HMEM_BASE     = 16'h0100;

endpackage

// File: rtl/hbus_arbiter_if.sv
// One request/ack bus link; master drives the request, slave returns ack and data.
interface hbus_arbiter_if;
  logic [15:0] addr;
  logic        rreq;
  logic        wreq;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;

  modport master (output addr, rreq, wreq, wdata, input rdata, ack);
  modport slave  (input addr, rreq, wreq, wdata, output rdata, ack);
endinterface

// File: rtl/hbus_watchdog.sv
// Transfer watchdog: down-counter reloaded whenever no transfer is pending,
// terminal count flags a forced completion and sets the sticky err.
module hbus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic s_ack,
  input  logic err_clr,
  output logic timeout,
  output logic err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign timeout = busy && (cnt == '0) && !s_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= TC_LOAD;
      err <= 1'b0;
    end else begin
      if (!busy || s_ack || timeout) cnt <= TC_LOAD;
      else                           cnt <= cnt - 1'b1;
      // a timeout in the same cycle beats a clear request
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/hbus_arbiter.sv
// Round-robin arbiter sharing the high-memory/IO subordinate bus between
// the core (m0) and the DMA/loader (m1), with a watchdog for unacked transfers.
//
//   state | meaning
//   IDLE  | no transfer; arbitrate pending requests into gnt
//   BUSY  | main[gnt] forwarded to the subordinate until ack, timeout or abort
module hbus_arbiter
  import hbus_arbiter_pkg::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] ERR_DATA = HBUS_ERR_DATA
) (
  input  logic           clk,
  input  logic           rst,
  hbus_arbiter_if.slave  m0,
  hbus_arbiter_if.slave  m1,
  hbus_arbiter_if.master s,
  input  logic           err_clr,
  output logic           err
);

  hbus_state_e state;
  logic        gnt;
  logic        last;

  logic        req0, req1, req_g;
  logic        busy, active, timeout, done;
  logic [7:0]  rd;

  assign req0   = m0.rreq | m0.wreq;
  assign req1   = m1.rreq | m1.wreq;
  assign req_g  = gnt ? req1 : req0;
  assign busy   = (state == BUSY);
  // a dropped request (abort) suppresses both the real and the forced ack
  assign active = busy && req_g;
  assign done   = active && (s.ack || timeout);
  assign rd     = s.ack ? s.rdata : ERR_DATA;

  hbus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (active),
    .s_ack   (s.ack),
    .err_clr (err_clr),
    .timeout (timeout),
    .err     (err)
  );

  assign s.addr  = busy ? (gnt ? m1.addr  : m0.addr)  : '0;
  assign s.rreq  = busy ? (gnt ? m1.rreq  : m0.rreq)  : 1'b0;
  assign s.wreq  = busy ? (gnt ? m1.wreq  : m0.wreq)  : 1'b0;
  assign s.wdata = busy ? (gnt ? m1.wdata : m0.wdata) : '0;

  assign m0.ack   = done && !gnt;
  assign m1.ack   = done &&  gnt;
  assign m0.rdata = (done && !gnt) ? rd : '0;
  assign m1.rdata = (done &&  gnt) ? rd : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt   <= (req0 && req1) ? ~last : req1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!req_g) begin
            state <= IDLE;
          end else if (s.ack || timeout) begin
            state <= IDLE;
            last  <= gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
